// File: rtl/rv32i_types.sv
// rv32i_types: shared types for the front-end instruction queue.
//   iq_entry_t        - one queued instruction: {pc, inst}
//   IQ_DEPTH_DEFAULT  - default number of queue entries
package rv32i_types;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } iq_entry_t;

    localparam int IQ_DEPTH_DEFAULT = 16;

endpackage

// File: rtl/instr_queue.sv
// instr_queue: circular instruction buffer between fetch and decode/dispatch.
// Fetch pushes {pc, inst} with a one-cycle enq strobe and uses the registered
// full flag as back-pressure; decode pops in order with deq_valid/deq. A flush
// from the ROB empties the queue in one cycle.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous reset, active-low
//   flush      in   discard all contents (beats enq/deq)
//   enq        in   write strobe, one entry per cycle
//   enq_pc     in   [31:0] PC of the incoming instruction
//   enq_inst   in   [31:0] incoming instruction word
//   full       out  count == DEPTH
//   empty      out  count == 0
//   count      out  [PTR_W:0] current occupancy
//   deq_valid  out  head entry is valid (!empty)
//   deq_pc     out  [31:0] head entry PC
//   deq_inst   out  [31:0] head entry instruction
//   deq        in   decode consumes the head entry this cycle
module instr_queue
    import rv32i_types::*;
#(
    parameter int DEPTH = IQ_DEPTH_DEFAULT,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              enq,
    input  logic [31:0]       enq_pc,
    input  logic [31:0]       enq_inst,
    output logic              full,
    output logic              empty,
    output logic [PTR_W:0]    count,
    output logic              deq_valid,
    output logic [31:0]       deq_pc,
    output logic [31:0]       deq_inst,
    input  logic              deq
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    // Flop array rather than SRAM so the head read stays combinational.
    iq_entry_t mem_q [DEPTH];

    logic      do_enq;
    logic      do_deq;
    logic      wr_en;
    iq_entry_t wr_entry;
    iq_entry_t head_entry;

    // Flags come only from the count register: no comb path from enq/deq.
    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign deq_valid = !empty;

    assign head_entry = mem_q[head_q];
    assign deq_pc     = head_entry.pc;
    assign deq_inst   = head_entry.inst;

    always_comb begin
        // full is the registered value, so a same-cycle deq never makes room.
        do_enq   = enq && !full;
        do_deq   = deq && !empty;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        wr_en    = 1'b0;
        wr_entry = '{pc: enq_pc, inst: enq_inst};

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_enq) begin
                wr_en  = 1'b1;
                tail_d = tail_q + PTR_W'(1);
            end
            if (do_deq) begin
                head_d = head_q + PTR_W'(1);
            end
            if (do_enq && !do_deq) begin
                count_d = count_q + (PTR_W + 1)'(1);
            end else if (!do_enq && do_deq) begin
                count_d = count_q - (PTR_W + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is never cleared; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            mem_q[tail_q] <= wr_entry;
        end
    end

`ifndef SYNTHESIS
    a_count_max : assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= FULL_CNT);
    a_valid_nonempty : assert property (@(posedge clk) disable iff (!rst_n)
        !(deq_valid && (count_q == '0)));
`endif

endmodule

// File: tb/tb_instr_queue.sv
module tb_instr_queue;

    localparam int DEPTH = 16;
    localparam int PTR_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              enq;
    logic [31:0]       enq_pc;
    logic [31:0]       enq_inst;
    logic              full;
    logic              empty;
    logic [PTR_W:0]    count;
    logic              deq_valid;
    logic [31:0]       deq_pc;
    logic [31:0]       deq_inst;
    logic              deq;

    always #5 clk = ~clk;

    instr_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .enq       (enq),
        .enq_pc    (enq_pc),
        .enq_inst  (enq_inst),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .deq_valid (deq_valid),
        .deq_pc    (deq_pc),
        .deq_inst  (deq_inst),
        .deq       (deq)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    // Reference model: the queue contents as an ordered list.
    ent_t model_q[$];
    // Scoreboard: entries decode is expected to receive, in order.
    ent_t sb_q[$];

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, then advance the model past the edge.
    task automatic step(input logic r, input logic f, input logic e, input logic d,
                        input logic [31:0] pc, input logic [31:0] inst);
        ent_t x;
        bit   acc_e;
        bit   acc_d;
        rst_n    = r;
        flush    = f;
        enq      = e;
        deq      = d;
        enq_pc   = pc;
        enq_inst = inst;
        acc_e = e && (model_q.size() < DEPTH);
        acc_d = d && (model_q.size() > 0);
        if (r && !f && acc_d) sb_q.push_back(model_q[0]);
        @(posedge clk);
        #1;
        if (!r || f) begin
            model_q.delete();
        end else begin
            if (acc_d) void'(model_q.pop_front());
            if (acc_e) begin
                x.pc   = pc;
                x.inst = inst;
                model_q.push_back(x);
            end
        end
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] inst);
        step(1'b1, 1'b0, 1'b1, 1'b0, pc, inst);
    endtask

    task automatic pop();
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    endtask

    // Monitor: state flags every cycle, head data whenever decode consumes.
    always @(negedge clk) begin
        if (mon_en) begin
            check("count", 64'(count), 64'(model_q.size()));
            check("empty", 64'(empty), 64'(model_q.size() == 0));
            check("full", 64'(full), 64'(model_q.size() == DEPTH));
            check("deq_valid", 64'(deq_valid), 64'(model_q.size() != 0));
            if (rst_n && !flush && deq && deq_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL deq_unexpected: got pc 0x%0h, expected no entry", deq_pc);
                end else begin
                    check("deq_pc", 64'(deq_pc), 64'(sb_q[0].pc));
                    check("deq_inst", 64'(deq_inst), 64'(sb_q[0].inst));
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        int r;
        rst_n = 1'b0; flush = 1'b0; enq = 1'b0; deq = 1'b0;
        enq_pc = '0; enq_inst = '0;

        // Reset then idle
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full", 64'(full), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_deq_valid", 64'(deq_valid), 64'd0);
        mon_en = 1'b1;
        idle();

        // Fill to DEPTH, then a dropped 17th write, then drain in order
        for (int i = 0; i < DEPTH; i++) push(32'hAAAAA000 + 32'(4 * i), 32'(i));
        check("fill_full", 64'(full), 64'd1);
        check("fill_count", 64'(count), 64'd16);
        push(32'hAAAAA040, 32'd16);
        check("drop_count", 64'(count), 64'd16);
        for (int i = 0; i < DEPTH; i++) pop();
        check("drain_empty", 64'(empty), 64'd1);

        // Streaming at count=3 for 40 cycles (pointers wrap)
        for (int i = 0; i < 3; i++) push(32'h1000 + 32'(4 * i), 32'hC000 + 32'(i));
        for (int i = 0; i < 40; i++)
            step(1'b1, 1'b0, 1'b1, 1'b1, 32'h2000 + 32'(4 * i), 32'hD000 + 32'(i));
        check("stream_count", 64'(count), 64'd3);

        // Flush with enq and deq in the same cycle at count=5
        push(32'h3000, 32'hE000);
        push(32'h3004, 32'hE001);
        check("preflush_count", 64'(count), 64'd5);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h3008, 32'hE002);
        check("flush_count", 64'(count), 64'd0);
        check("flush_empty", 64'(empty), 64'd1);

        // Enq and deq together while empty: no bypass
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'h4444_0000, 32'h1234_5678);
        check("ed_empty_count", 64'(count), 64'd1);
        check("ed_empty_pc", 64'(deq_pc), 64'h4444_0000);
        pop();
        pop();
        check("deq_when_empty", 64'(count), 64'd0);

        // Reset in the middle of operation with enq asserted
        for (int i = 0; i < 9; i++) push(32'h5000 + 32'(4 * i), 32'hF000 + 32'(i));
        check("premid_count", 64'(count), 64'd9);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h5FFF, 32'hFFFF);
        check("midrst_count", 64'(count), 64'd0);
        check("midrst_empty", 64'(empty), 64'd1);
        push(32'h6000, 32'hA0);
        push(32'h6004, 32'hA1);
        pop();
        pop();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 199));
            step((r != 0) ? 1'b1 : 1'b0,
                 (r >= 1 && r <= 4) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 99) < 60),
                 1'($urandom_range(0, 99) < 50),
                 $urandom, $urandom);
        end
        // Drain what is left so every pushed expectation is consumed
        for (int i = 0; i < DEPTH + 1; i++) pop();
        idle();

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
